// File: rtl/svlib_arb_pkg.sv
// Shared types and the round-robin pick function for the registered arbiter.
package svlib_arb_pkg;

  localparam int MAX_REQ = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // One-hot of the first requester found scanning ptr, ptr+1, ..., wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [3:0]         ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] onehot;
    logic               found;
    int                 idx;
    onehot = '0;
    found  = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && req[idx[3:0]]) begin
        onehot[idx[3:0]] = 1'b1;
        found            = 1'b1;
      end
    end
    return onehot;
  endfunction

endpackage

// File: rtl/rr_reg_arbiter_if.sv
// Requester-side and consumer-side signals of the registered round-robin arbiter.
interface rr_reg_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
);
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] req;
  logic [WIDTH-1:0] req_data [N_REQ];
  logic [N_REQ-1:0] gnt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [SRC_W-1:0] out_src;

  modport slave (
    input  req, req_data, out_ready,
    output gnt, out_valid, out_data, out_src
  );

  modport master (
    output req, req_data, out_ready,
    input  gnt, out_valid, out_data, out_src
  );
endinterface

// File: rtl/dff_async_rst_n_en.sv
// Enabled register with asynchronous active-low clear.
module dff_async_rst_n_en #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter feeding a single shared output register (IDLE = empty, HOLD = full).
module rr_reg_arbiter
  import svlib_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4
) (
  input  logic              clk,
  input  logic              async_rst_n,
  rr_reg_arbiter_if.slave   bus,
  output state_t            state_dbg
);

  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Handshakes: requester i transfers on an edge with req[i] & gnt[i]; the consumer
  // takes out_data on an edge with out_valid & out_ready. A grant is offered only when
  // the register is empty or is being emptied on the same edge.
  state_t             state, state_nxt;
  logic [SRC_W-1:0]   ptr, ptr_nxt, win_idx;
  logic [MAX_REQ-1:0] req_ext;
  logic [3:0]         ptr_ext;
  logic [N_REQ-1:0]   gnt;
  logic               grant_en, xfer, consume;
  logic [WIDTH-1:0]   win_data;
  logic [WIDTH+SRC_W-1:0] held;

  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = bus.req;
    ptr_ext              = '0;
    ptr_ext[SRC_W-1:0]   = ptr;
    grant_en = async_rst_n && ((state == IDLE) || bus.out_ready);
    gnt      = grant_en ? N_REQ'(rr_pick(req_ext, ptr_ext, N_REQ)) : '0;
    xfer     = |gnt;
    consume  = (state == HOLD) && bus.out_ready;
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) win_idx = SRC_W'(i);
    end
    win_data = bus.req_data[win_idx];
  end

  always_comb begin
    ptr_nxt = ptr;
    if (xfer) ptr_nxt = (win_idx == SRC_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = HOLD;
      HOLD:    if (consume && !xfer) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  dff_async_rst_n_en #(.W(WIDTH + SRC_W)) u_store (
    .clk   (clk),
    .rst_n (async_rst_n),
    .en    (xfer),
    .d     ({win_data, win_idx}),
    .q     (held)
  );

  assign bus.gnt       = gnt;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = held[WIDTH+SRC_W-1:SRC_W];
  assign bus.out_src   = held[SRC_W-1:0];
  assign state_dbg     = state;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Bench for rr_reg_arbiter: directed vectors plus a randomised phase, with a consume-side scoreboard.
module tb_rr_reg_arbiter;
  import svlib_arb_pkg::*;

  localparam int WIDTH = 8;
  localparam int N_REQ = 4;
  localparam int SRC_W = 2;

  logic   clk = 1'b0;
  logic   async_rst_n = 1'b0;
  state_t state_dbg;

  int total = 0;
  int bad   = 0;
  logic [SRC_W+WIDTH-1:0] exp_q[$];
  logic [SRC_W+WIDTH-1:0] exp_item;

  logic [N_REQ-1:0] last_gnt, r, eg;
  logic             rdy, m_hold;
  int               m_ptr, w, j;
  int               waited [N_REQ];

  rr_reg_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  rr_reg_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ)) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .bus         (bus),
    .state_dbg   (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, check the combinational grant, queue the transfer.
  task automatic cycle(input logic [N_REQ-1:0] rq, input logic ready,
                       input logic [N_REQ-1:0] exp_gnt, input string nm);
    bus.req       = rq;
    bus.out_ready = ready;
    @(negedge clk);
    last_gnt = bus.gnt;
    chk(nm, 32'(bus.gnt), 32'(exp_gnt));
    for (int i = 0; i < N_REQ; i++) begin
      if (exp_gnt[i] && rq[i]) exp_q.push_back({SRC_W'(i), bus.req_data[i]});
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every consume must match the oldest queued transfer.
  always @(negedge clk) begin
    if (async_rst_n && bus.out_valid && bus.out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got src=%0d data=%0h want nothing", bus.out_src, bus.out_data);
      end else begin
        exp_item = exp_q.pop_front();
        if ({bus.out_src, bus.out_data} !== exp_item) begin
          bad++;
          $display("FAIL sb_data: got src=%0d data=%0h want src=%0d data=%0h",
                   bus.out_src, bus.out_data, exp_item[SRC_W+WIDTH-1:WIDTH], exp_item[WIDTH-1:0]);
        end
      end
    end
  end

  initial begin
    bus.req       = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) bus.req_data[i] = '0;
    for (int i = 0; i < N_REQ; i++) waited[i] = 0;

    // Reset state, with requests present to show grants are masked
    #2;
    bus.req = 4'b1111;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_data",  32'(bus.out_data),  32'd0);
    chk("rst_src",   32'(bus.out_src),   32'd0);
    chk("rst_gnt",   32'(bus.gnt),       32'd0);
    chk("rst_state", 32'(state_dbg),     32'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    bus.req     = '0;
    async_rst_n = 1'b1;

    // Idle: nothing requested
    repeat (5) begin
      cycle(4'b0000, 1'b0, 4'b0000, "idle_gnt");
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_data",  32'(bus.out_data),  32'd0);
    end

    // Full request, back-to-back at one transfer per cycle
    for (int i = 0; i < N_REQ; i++) bus.req_data[i] = 8'(8'h10 + i);
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, 1'b1, 4'(1 << (k % 4)), "rr_gnt");
      chk("rr_valid", 32'(bus.out_valid), 32'd1);
      chk("rr_src",   32'(bus.out_src),   32'(k % 4));
      chk("rr_data",  32'(bus.out_data),  32'(8'h10 + (k % 4)));
    end
    cycle(4'b0000, 1'b1, 4'b0000, "drain1");
    chk("drain1_valid", 32'(bus.out_valid), 32'd0);

    // Walk ptr to 3, then the top requester wraps ptr to 0
    cycle(4'b0010, 1'b1, 4'b0010, "walk_p2");
    cycle(4'b0100, 1'b1, 4'b0100, "walk_p3");
    cycle(4'b1000, 1'b1, 4'b1000, "last_gnt");
    chk("last_src", 32'(bus.out_src), 32'd3);
    cycle(4'b1001, 1'b1, 4'b0001, "wrap_gnt");
    chk("wrap_src", 32'(bus.out_src), 32'd0);
    cycle(4'b0000, 1'b1, 4'b0000, "drain2");

    // Stall with out_ready low, then release
    bus.req_data[1] = 8'hA5;
    cycle(4'b0010, 1'b0, 4'b0010, "a5_xfer");
    bus.req_data[1] = 8'h5A;
    repeat (4) begin
      cycle(4'b0010, 1'b0, 4'b0000, "stall_gnt");
      chk("stall_data",  32'(bus.out_data),  32'hA5);
      chk("stall_valid", 32'(bus.out_valid), 32'd1);
    end
    cycle(4'b0010, 1'b1, 4'b0010, "resume_gnt");
    chk("resume_data", 32'(bus.out_data), 32'h5A);
    chk("resume_src",  32'(bus.out_src),  32'd1);
    cycle(4'b0000, 1'b1, 4'b0000, "drain3");

    // Reset mid-cycle while holding data
    bus.req_data[2] = 8'h3C;
    cycle(4'b0100, 1'b0, 4'b0100, "hold_3c");
    chk("hold_data", 32'(bus.out_data), 32'h3C);
    #2;
    async_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data",  32'(bus.out_data),  32'd0);
    chk("mid_rst_src",   32'(bus.out_src),   32'd0);
    chk("mid_rst_gnt",   32'(bus.gnt),       32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    async_rst_n = 1'b1;
    cycle(4'b1010, 1'b1, 4'b0010, "ptr_reset");
    cycle(4'b0100, 1'b1, 4'b0100, "post_rst_gnt");
    cycle(4'b0000, 1'b1, 4'b0000, "drain4");

    // Randomised traffic against a small reference model; ptr is now 3, register empty
    m_ptr  = 3;
    m_hold = 1'b0;
    r      = '0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < N_REQ; i++) begin
        r[i] = r[i] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 1) != 0);
        bus.req_data[i] = 8'($urandom_range(0, 255));
      end
      rdy = ($urandom_range(0, 3) != 0);
      eg  = '0;
      w   = 0;
      if (!m_hold || rdy) begin
        for (int k = 0; k < N_REQ; k++) begin
          j = (m_ptr + k) % N_REQ;
          if ((eg == '0) && r[j]) begin
            eg[j] = 1'b1;
            w     = j;
          end
        end
      end
      cycle(r, rdy, eg, "rand_gnt");
      for (int i = 0; i < N_REQ; i++) begin
        if (!r[i]) waited[i] = 0;
        else if (last_gnt[i]) begin
          chk("fair_wait", 32'(waited[i] <= N_REQ - 1), 32'd1);
          waited[i] = 0;
        end else if (last_gnt != '0) waited[i]++;
      end
      if (eg != '0) begin
        m_ptr  = (w + 1) % N_REQ;
        m_hold = 1'b1;
      end else if (m_hold && rdy) begin
        m_hold = 1'b0;
      end
    end

    cycle(4'b0000, 1'b1, 4'b0000, "final_drain");
    cycle(4'b0000, 1'b1, 4'b0000, "final_idle");
    chk("final_valid", 32'(bus.out_valid), 32'd0);
    chk("sb_empty",    32'(exp_q.size()),  32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
